mdu_pipe: RTL and testbench
===========================

# mdu_pipe

Iterative-latency multiply/divide unit for the E stage of the 5-stage pipeline. It owns the HI/LO registers and accepts mult/multu/div/divu/mthi/mtlo from the E-stage control decode. It models the fixed multi-cycle latency with a busy countdown, which the D-stage hazard logic uses to stall later HI/LO instructions. HI/LO are read combinationally by the E-stage result mux for mfhi/mflo, and the result travels down the pipeline register into M.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (range 1–15)
- DIV_CYCLES, 10: busy cycles for div/divu (range 1–15)
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- start  in  1  E-stage instruction is an MDU op; sampled on rising edge
- mdu_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- a  in  32  forwarded rs value
- b  in  32  forwarded rt value
- busy  out  1  operation in flight
- hi  out  32  current HI
- lo  out  32  current LO

## Operation
- State: hi, lo, pend_hi, pend_lo (32 each), cnt (4 bits), pend_valid (1). busy = (cnt != 0).
- Accepted op: start=1, busy=0, and mdu_op in 1..6 at a rising edge. An op with start=1 while busy=1 is ignored entirely: no state change. The hazard unit guarantees this never occurs in legal flow.
- mult: {pend_hi,pend_lo} = signed(a)*signed(b), 64-bit. cnt = MULT_CYCLES.
- multu: the same product with both operands unsigned.
- div: pend_lo = signed quotient, truncated toward zero. pend_hi = remainder, which takes the sign of the dividend. cnt = DIV_CYCLES.
- Special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient to LO and unsigned remainder to HI.
- Divide by zero (b=0): pend_valid=0. The unit still counts DIV_CYCLES, then leaves hi/lo unchanged.
- mthi: hi = a at the accepting edge. No busy; lo unchanged.
- mtlo: lo = a at the accepting edge. No busy; hi unchanged.
- While cnt != 0, each edge decrements cnt. On the edge where cnt goes 1→0, if pend_valid=1, then hi=pend_hi and lo=pend_lo.
- Operands are captured at the accepting edge. Later changes on a/b have no effect.

## Timing
- Reset (reset=0, asynchronous): hi=0, lo=0, cnt=0, busy=0, pend_hi/pend_lo/pend_valid=0.
- Reset deassertion takes effect at the next rising edge.
- Reset mid-operation aborts the operation, and no HI/LO update occurs.
- Accepting edge E0 for mult: busy=1 from E0 through the edge E0+MULT_CYCLES.
- At edge E0+MULT_CYCLES, busy falls and new hi/lo are visible in the same cycle.
- Total visible latency is MULT_CYCLES edges after E0. The same rule applies to div with DIV_CYCLES.
- A new op may be accepted at the edge where busy has already read 0. Back-to-back operations therefore leave no idle cycle beyond the busy window.
- mthi/mtlo: the new value is visible on hi/lo the cycle after the accepting edge.
- hi/lo/busy are registered or pure decode of registered state. There is no combinational path from inputs to outputs.
- Hazard contract, implemented outside this block: D stalls any MDU op or mfhi/mflo while (busy | start) is 1.

## Configuration
- MDU_DIV_EN defined: divider is compiled in, and div/divu behave as above.
- MDU_DIV_EN undefined: no divider logic. div/divu are accepted as no-ops: cnt stays 0, busy stays 0, hi/lo unchanged.
- mult/multu/mthi/mtlo are unaffected by the macro.

## Test plan
- mult, a=0xFFFFFFFE (−2), b=3:
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo hold their old values during busy.
- multu, a=0xFFFFFFFF, b=0xFFFFFFFF: after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div cases:
  - a=−7, b=2: after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - b=0 with hi=0x11, lo=0x22 preset: busy for 10 cycles, then hi=0x11, lo=0x22.
  - With MDU_DIV_EN undefined, div gives busy=0 throughout and hi/lo unchanged.
- mthi a=0x1234 then mtlo a=0x5678 on consecutive edges: hi=0x1234, then lo=0x5678, busy never asserts.
- mult started, then start with mthi during busy: mthi is ignored, and the final hi/lo equal the product.
- Second mult issued on the first edge after busy falls: accepted, with correct latency.
- reset pulled low in the 3rd busy cycle of a mult: busy=0, hi=lo=0 immediately. After release there is no late HI/LO write.

Source files
------------

// File: rtl/mdu_pipe_if.sv
// mdu_pipe_if: E-stage control/operand bundle into the multiply/divide unit
// together with the status/result signals read back by the pipeline.
//   start, mdu_op, a, b : issued by the pipeline (master)
//   busy, hi, lo        : driven by the MDU (slave)
interface mdu_pipe_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, mdu_op, a, b, input busy, hi, lo);
    modport slave  (input start, mdu_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_pipe.sv
// mdu_pipe: iterative-latency multiply/divide unit for the E stage.
// Owns HI/LO. The result of mult/multu/div/divu is computed at the accepting
// edge, parked in pend_hi/pend_lo, and committed to HI/LO when the busy
// countdown expires, so the pipeline sees the fixed latency of a real
// iterative unit. mthi/mtlo write HI/LO directly and never raise busy.
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-low clear of all state
//   mdu   : mdu_pipe_if.slave (start, mdu_op, a, b in; busy, hi, lo out)
// Build option: define MDU_DIV_EN to include the divider; without it div/divu
// are accepted as no-ops.
module mdu_pipe #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_pipe_if.slave mdu
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_valid_q, pend_valid_d;
    logic        accept;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u;

    assign a_sx   = {{32{mdu.a[31]}}, mdu.a};
    assign b_sx   = {{32{mdu.b[31]}}, mdu.b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, mdu.a} * {32'd0, mdu.b};

`ifdef MDU_DIV_EN
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    // One unsigned divider serves both div and divu: signed operands are
    // reduced to magnitudes and the signs are reapplied afterwards. This also
    // yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    logic        a_neg, b_neg, div_by_zero;
    logic [31:0] dvd, dvs, dvs_safe, uq, ur, quot, rem;

    assign a_neg       = (mdu.mdu_op == OP_DIV) && mdu.a[31];
    assign b_neg       = (mdu.mdu_op == OP_DIV) && mdu.b[31];
    assign dvd         = a_neg ? -mdu.a : mdu.a;
    assign dvs         = b_neg ? -mdu.b : mdu.b;
    assign div_by_zero = (mdu.b == 32'd0);
    // Keep the divider operand defined when b is zero; the result is discarded.
    assign dvs_safe    = div_by_zero ? 32'd1 : dvs;
    assign uq          = dvd / dvs_safe;
    assign ur          = dvd % dvs_safe;
    assign quot        = (a_neg ^ b_neg) ? -uq : uq;
    assign rem         = a_neg ? -ur : ur;
`endif

    assign accept = mdu.start && (cnt_q == 4'd0) &&
                    (mdu.mdu_op != 3'd0) && (mdu.mdu_op != 3'd7);

    always_comb begin
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;

        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                pend_valid_d = 1'b0;
                if (pend_valid_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (accept) begin
            case (mdu.mdu_op)
                OP_MULT: begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    pend_valid_d = 1'b1;
                    cnt_d        = MULT_CNT;
                end
                OP_MULTU: begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    pend_valid_d = 1'b1;
                    cnt_d        = MULT_CNT;
                end
`ifdef MDU_DIV_EN
                OP_DIV, OP_DIVU: begin
                    pend_hi_d    = rem;
                    pend_lo_d    = quot;
                    pend_valid_d = !div_by_zero;
                    cnt_d        = DIV_CNT;
                end
`endif
                OP_MTHI: hi_d = mdu.a;
                OP_MTLO: lo_d = mdu.a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q         <= '0;
            lo_q         <= '0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mdu.busy = (cnt_q != 4'd0);
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_mdu_pipe.sv
module tb_mdu_pipe;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mdu_pipe_if mdu ();

    mdu_pipe #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          exp_cyc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op, scrambles the operands after the accepting edge, and
    // counts busy cycles (bounded) while checking HI/LO stay put.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic held);
        logic [31:0] h0, l0;
        h0 = mdu.hi;
        l0 = mdu.lo;
        mdu.start  = 1'b1;
        mdu.mdu_op = op;
        mdu.a      = a;
        mdu.b      = b;
        step();
        mdu.start  = 1'b0;
        mdu.mdu_op = 3'd0;
        mdu.a      = $urandom;
        mdu.b      = $urandom;
        cyc  = 0;
        held = 1'b1;
        while (mdu.busy && cyc < 40) begin
            if (mdu.hi !== h0 || mdu.lo !== l0) held = 1'b0;
            step();
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        logic        held;
        logic [31:0] pre_hi, pre_lo;

        checks = 0;
        errors = 0;
        mdu.start  = 1'b0;
        mdu.mdu_op = 3'd0;
        mdu.a      = '0;
        mdu.b      = '0;
        reset      = 1'b0;

        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        5, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{3'd5, 32'h11,       32'd0,        0, 32'h11,       32'h00000001};
        vecs[3]  = '{3'd6, 32'h22,       32'd0,        0, 32'h11,       32'h22};
`ifdef MDU_DIV_EN
        vecs[4]  = '{3'd3, 32'd5,        32'd0,        10, 32'h11,       32'h22};
        vecs[5]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000};
        vecs[7]  = '{3'd4, 32'd100,      32'd7,        10, 32'd2,        32'd14};
`else
        vecs[4]  = '{3'd3, 32'd5,        32'd0,        0, 32'h11,       32'h22};
        vecs[5]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        0, 32'h11,       32'h22};
        vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 32'h11,       32'h22};
        vecs[7]  = '{3'd4, 32'd100,      32'd7,        0, 32'h11,       32'h22};
`endif
        vecs[8]  = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 5, 32'hC0000000, 32'h80000000};
        vecs[9]  = '{3'd7, 32'hDEAD,     32'hBEEF,     0, 32'hC0000000, 32'h80000000};
        vecs[10] = '{3'd0, 32'hDEAD,     32'hBEEF,     0, 32'hC0000000, 32'h80000000};

        #12;
        chk("reset_busy", {31'd0, mdu.busy}, 32'd0);
        chk("reset_hi", mdu.hi, 32'd0);
        chk("reset_lo", mdu.lo, 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, held);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_hold", i), {31'd0, held}, 32'd1);
            chk($sformatf("v%0d_hi", i), mdu.hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), mdu.lo, vecs[i].exp_lo);
        end

        // mthi then mtlo on consecutive edges
        mdu.start = 1'b1; mdu.mdu_op = 3'd5; mdu.a = 32'h1234;
        step();
        chk("mthi_hi", mdu.hi, 32'h1234);
        chk("mthi_busy", {31'd0, mdu.busy}, 32'd0);
        mdu.mdu_op = 3'd6; mdu.a = 32'h5678;
        step();
        mdu.start = 1'b0; mdu.mdu_op = 3'd0;
        chk("mtlo_lo", mdu.lo, 32'h5678);
        chk("mtlo_hi", mdu.hi, 32'h1234);
        chk("mtlo_busy", {31'd0, mdu.busy}, 32'd0);

        // mthi issued during a multiply is ignored
        mdu.start = 1'b1; mdu.mdu_op = 3'd1; mdu.a = 32'd6; mdu.b = 32'd7;
        step();
        mdu.start = 1'b0; mdu.mdu_op = 3'd0;
        step();
        mdu.start = 1'b1; mdu.mdu_op = 3'd5; mdu.a = 32'h999;
        step();
        mdu.start = 1'b0; mdu.mdu_op = 3'd0;
        cyc = 0;
        while (mdu.busy && cyc < 40) begin step(); cyc++; end
        chk("ign_cycles", 32'(cyc), 32'd3);
        chk("ign_hi", mdu.hi, 32'd0);
        chk("ign_lo", mdu.lo, 32'd42);

        // back-to-back multiplies with no idle cycle
        run_op(3'd1, 32'd3, 32'd4, cyc, held);
        chk("b2b1_lo", mdu.lo, 32'd12);
        run_op(3'd2, 32'd5, 32'd5, cyc, held);
        chk("b2b2_cycles", 32'(cyc), 32'd5);
        chk("b2b2_lo", mdu.lo, 32'd25);

        // reset asserted in the 3rd busy cycle aborts the multiply
        mdu.start = 1'b1; mdu.mdu_op = 3'd1; mdu.a = 32'h100; mdu.b = 32'h100;
        step();
        mdu.start = 1'b0; mdu.mdu_op = 3'd0;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, mdu.busy}, 32'd0);
        chk("rst_hi", mdu.hi, 32'd0);
        chk("rst_lo", mdu.lo, 32'd0);
        #3;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) step();
        chk("post_rst_busy", {31'd0, mdu.busy}, 32'd0);
        chk("post_rst_hi", mdu.hi, 32'd0);
        chk("post_rst_lo", mdu.lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
